mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Single-port memory arbiter and sequencer that shares one unified instruction/data memory between the CPU fetch port (PC) and the load/store port (LDUR/STUR in the datapath). It grants one access at a time, drives the memory with registered request signals, waits for the memory's ready response, and returns the read data with a one-cycle done pulse. Data accesses have priority, with a starvation guard so fetch always makes progress.

## Interface
Parameters:
- ADDR_W, 64, address width in bits
- DATA_W, 64, data width in bits
- STARVE_MAX, 4, max consecutive data grants while a fetch is pending; range 1..15

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  asynchronous, active-low; 0 clears all state immediately
- if_req  in  1  fetch request, held until if_done
- if_addr  in  ADDR_W  fetch address, stable while if_req=1
- if_rdata  out  DATA_W  fetched word, valid when if_done=1
- if_done  out  1  one-cycle fetch completion pulse
- d_req  in  1  load/store request, held until d_done
- d_we  in  1  1=store (STUR), 0=load (LDUR)
- d_addr  in  ADDR_W  data address, stable while d_req=1
- d_wdata  in  DATA_W  store data, stable while d_req=1
- d_rdata  out  DATA_W  load data, valid when d_done=1
- d_done  out  1  one-cycle data completion pulse
- mem_req  out  1  memory access active
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid with mem_ready
- mem_ready  in  1  memory completes current access this cycle
- owner  out  1  0=fetch, 1=data; meaningful while mem_req=1

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE: if no request, stay. Otherwise pick owner, latch addr/we/wdata into output registers, go BUSY. Fetch grants force mem_we=0, mem_wdata=0.
- Selection: only one requesting -> that one. Both -> data, unless streak==STARVE_MAX -> fetch.
- streak (4-bit): +1 on each data grant made while if_req=1 (saturates at STARVE_MAX); cleared on any fetch grant and on data grant with if_req=0.
- BUSY: mem_req=1, mem_* held constant. On mem_ready=1: capture mem_rdata into owner's rdata register (load/fetch only), go RESP. mem_ready outside BUSY ignored.
- RESP: mem_req=0; owner's done=1 for exactly this cycle; requests ignored; go IDLE. Requester drops req during/after RESP; req still high in IDLE is a new access.
- Stores: d_rdata not updated (holds previous load value).
- if_rdata/d_rdata hold value until next completion of same port.
- Never both done outputs high; never mem_req in IDLE or RESP.

## Timing
- Reset (reset=0, asynchronous): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, owner=0, if_done=0, d_done=0, if_rdata=0, d_rdata=0, streak=0. In-flight access abandoned; no done issued.
- Latency: req seen at edge N -> mem_req high cycle N+1; mem_ready in cycle N+1+k (k>=0) -> done high cycle N+2+k.
- Minimum: 3 cycles per access (IDLE, BUSY, RESP); back-to-back throughput 1 access / 3 cycles with zero-wait memory.
- Requests arriving during BUSY/RESP wait; arbitration uses req values at the IDLE edge only.
- Reset release takes effect synchronously to the first subsequent rising edge.

## Test plan
- Fetch alone, mem_ready tied 1: if_req=1, if_addr=0x40 at cycle 0 -> cycle 1 mem_req=1, mem_addr=0x40, mem_we=0, owner=0; cycle 2 if_done=1, if_rdata=mem_rdata (0x8B020020); cycle 3 idle.
- Simultaneous: if_req=d_req=1 (d_addr=0x100, load), streak=0 -> data granted first (owner=1), d_done, then fetch granted next IDLE.
- Starvation, STARVE_MAX=4: d_req and if_req held continuously, each requester reissuing after done -> grant order D,D,D,D,F,D,D,D,D,F.
- Wait states: load at 0x200 with mem_ready low 5 cycles -> mem_req high 6 cycles, mem_addr stable 0x200, d_done exactly one cycle after mem_ready.
- Store: d_we=1, d_addr=0x108, d_wdata=0xDEAD -> mem_we=1, mem_wdata=0xDEAD; d_done pulses; d_rdata unchanged from prior load.
- Reset mid-BUSY: assert reset=0 during wait state -> mem_req, done outputs, rdata, streak to 0 same cycle; after release with no req, stays IDLE, no done pulse.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter/sequencer shared by instruction fetch and load/store.
// Data accesses win ties; a streak counter guarantees fetch progress.
module mem_arbiter #(
    parameter int ADDR_W     = 64,
    parameter int DATA_W     = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_done,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              owner
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    localparam logic [3:0] SMAX = 4'(STARVE_MAX);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] streak;
    logic       grant_d;
    logic       grant_f;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        grant_d   = 1'b0;
        grant_f   = 1'b0;
        unique case (state)
            IDLE: begin
                grant_d = d_req && (!if_req || streak != SMAX);
                grant_f = if_req && !grant_d;
                if (grant_d || grant_f) begin
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (mem_ready) begin
                    state_nxt = RESP;
                end
            end
            RESP: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Request and done strobes decode straight from the state register.
    assign mem_req = (state == BUSY);
    assign if_done = (state == RESP) && !owner;
    assign d_done  = (state == RESP) && owner;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            owner     <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            streak    <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
        end else begin
            if (grant_d) begin
                owner     <= 1'b1;
                mem_we    <= d_we;
                mem_addr  <= d_addr;
                mem_wdata <= d_wdata;
                if (!if_req) begin
                    streak <= '0;
                end else if (streak != SMAX) begin
                    streak <= streak + 4'd1;
                end
            end else if (grant_f) begin
                owner     <= 1'b0;
                mem_we    <= 1'b0;
                mem_addr  <= if_addr;
                mem_wdata <= '0;
                streak    <= '0;
            end
            // Stores leave d_rdata holding the last load result.
            if (state == BUSY && mem_ready) begin
                if (!owner) begin
                    if_rdata <= mem_rdata;
                end else if (!mem_we) begin
                    d_rdata <= mem_rdata;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter: vector table, directed corner sequences,
// and randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int SMAX = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        if_req;
    logic [63:0] if_addr;
    logic [63:0] if_rdata;
    logic        if_done;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic [63:0] d_rdata;
    logic        d_done;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [63:0] mem_rdata;
    logic        mem_ready;
    logic        owner;

    int n_chk  = 0;
    int n_fail = 0;

    mem_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(SMAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_done   (if_done),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_done    (d_done),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_ready (mem_ready),
        .owner     (owner)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          is_d;
        bit          we;
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [63:0] rdata;
        int          waits;
        logic [63:0] exp_ird;
        logic [63:0] exp_drd;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic run_vec(input vec_t v);
        if_req    = !v.is_d;
        d_req     = v.is_d;
        d_we      = v.we;
        if_addr   = v.is_d ? 64'hFFFF_0000 : v.addr;
        d_addr    = v.is_d ? v.addr : 64'hEEEE_0000;
        d_wdata   = v.wdata;
        mem_ready = 1'b1;
        mem_rdata = 64'hBAD;
        tick();
        for (int c = 0; c <= v.waits; c++) begin
            chk("vec_mem_req", mem_req, 1);
            chk("vec_addr", mem_addr, v.addr);
            chk("vec_owner", owner, v.is_d);
            chk("vec_we", mem_we, v.is_d & v.we);
            chk("vec_wdata", mem_wdata, v.is_d ? v.wdata : 64'h0);
            chk("vec_done_early", if_done | d_done, 0);
            mem_ready = (c == v.waits);
            mem_rdata = mem_ready ? v.rdata : ~v.rdata;
            tick();
        end
        if_req = 1'b0;
        d_req  = 1'b0;
        chk("vec_resp_req", mem_req, 0);
        chk("vec_if_done", if_done, !v.is_d);
        chk("vec_d_done", d_done, v.is_d);
        chk("vec_if_rdata", if_rdata, v.exp_ird);
        chk("vec_d_rdata", d_rdata, v.exp_drd);
        mem_ready = 1'b1;
        tick();
        chk("vec_idle_req", mem_req, 0);
        chk("vec_idle_done", if_done | d_done, 0);
    endtask

    // Reference model state for randomized traffic.
    bit          m_active;
    bit          m_resp;
    bit          m_owner;
    bit          m_we;
    logic [63:0] m_addr;
    logic [63:0] m_wdata;
    logic [63:0] e_ird;
    logic [63:0] e_drd;
    int          cnt;
    bit          ip;
    bit          dp;

    task automatic model_edge();
        if (m_resp) begin
            m_resp = 0;
        end else if (m_active) begin
            if (mem_ready) begin
                if (!m_owner) e_ird = mem_rdata;
                else if (!m_we) e_drd = mem_rdata;
                m_active = 0;
                m_resp   = 1;
            end
        end else if (ip || dp) begin
            if (dp && (!ip || cnt < SMAX)) begin
                m_owner = 1;
                m_addr  = d_addr;
                m_we    = d_we;
                m_wdata = d_wdata;
                cnt     = ip ? cnt + 1 : 0;
            end else begin
                m_owner = 0;
                m_addr  = if_addr;
                m_we    = 0;
                m_wdata = 0;
                cnt     = 0;
            end
            m_active = 1;
        end
    endtask

    vec_t tbl[7];
    bit   exp_ord[10];

    initial begin
        tbl[0] = '{0, 0, 64'h40, 64'h77, 64'h8B020020, 0, 64'h8B020020, 64'h0};
        tbl[1] = '{1, 0, 64'h100, 64'h55, 64'h1111, 0, 64'h8B020020, 64'h1111};
        tbl[2] = '{1, 0, 64'h200, 64'h0, 64'h2222, 5, 64'h8B020020, 64'h2222};
        tbl[3] = '{1, 1, 64'h108, 64'hDEAD, 64'h9999, 0, 64'h8B020020, 64'h2222};
        tbl[4] = '{0, 0, 64'h44, 64'h1234, 64'hABCD, 2, 64'hABCD, 64'h2222};
        tbl[5] = '{1, 1, 64'h300, 64'hFFFF_FFFF_FFFF_FFFF, 64'h7777, 3,
                   64'hABCD, 64'h2222};
        tbl[6] = '{1, 0, 64'hFFFF_FFFF_FFFF_FFF8, 64'h0, 64'h0123_4567_89AB_CDEF, 1,
                   64'hABCD, 64'h0123_4567_89AB_CDEF};
        exp_ord = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

        reset     = 1'b0;
        if_req    = 1'b0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        if_addr   = '0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        tick();
        tick();
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_owner", owner, 0);
        chk("rst_done", {if_done, d_done}, 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_d_rdata", d_rdata, 0);
        reset = 1'b1;
        tick();
        chk("post_rst_idle", mem_req, 0);

        foreach (tbl[i]) run_vec(tbl[i]);

        // Simultaneous requests: data first, then the waiting fetch.
        if_req    = 1'b1;
        d_req     = 1'b1;
        d_we      = 1'b0;
        d_addr    = 64'h100;
        if_addr   = 64'h80;
        mem_ready = 1'b1;
        mem_rdata = 64'h5150;
        tick();
        chk("sim_owner1", owner, 1);
        chk("sim_addr1", mem_addr, 64'h100);
        tick();
        chk("sim_d_done", d_done, 1);
        chk("sim_if_done0", if_done, 0);
        chk("sim_d_rdata", d_rdata, 64'h5150);
        d_req = 1'b0;
        mem_rdata = 64'h6160;
        tick();
        tick();
        chk("sim_owner2", owner, 0);
        chk("sim_addr2", mem_addr, 64'h80);
        tick();
        chk("sim_if_done", if_done, 1);
        chk("sim_if_rdata", if_rdata, 64'h6160);
        if_req = 1'b0;
        tick();

        // Both held continuously: starvation guard interleaves fetch.
        if_req    = 1'b1;
        d_req     = 1'b1;
        mem_rdata = 64'hCAFE;
        for (int g = 0; g < 10; g++) begin
            tick();
            chk("starve_req", mem_req, 1);
            chk("starve_owner", owner, exp_ord[g]);
            tick();
            chk("starve_if_done", if_done, !exp_ord[g]);
            chk("starve_d_done", d_done, exp_ord[g]);
            if (g == 9) begin
                if_req = 1'b0;
                d_req  = 1'b0;
            end
            tick();
        end

        // Build streak to the limit, then reset mid-BUSY.
        if_req    = 1'b1;
        d_req     = 1'b1;
        d_addr    = 64'h500;
        if_addr   = 64'h600;
        mem_ready = 1'b0;
        for (int g = 0; g < 3; g++) begin
            tick();
            chk("pre_rst_owner", owner, 1);
            mem_ready = 1'b1;
            tick();
            mem_ready = 1'b0;
            tick();
        end
        tick();
        chk("pre_rst_owner4", owner, 1);
        tick();
        chk("pre_rst_busy", mem_req, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_mem_req", mem_req, 0);
        chk("arst_done", {if_done, d_done}, 0);
        chk("arst_if_rdata", if_rdata, 0);
        chk("arst_d_rdata", d_rdata, 0);
        chk("arst_addr", mem_addr, 0);
        chk("arst_owner", owner, 0);
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("rel_idle_req", mem_req, 0);
            chk("rel_idle_done", {if_done, d_done}, 0);
        end
        if_req = 1'b1;
        d_req  = 1'b1;
        tick();
        chk("rel_req", mem_req, 1);
        chk("rel_streak_clr", owner, 1);
        mem_ready = 1'b1;
        tick();
        chk("rel_d_done", d_done, 1);
        if_req = 1'b0;
        d_req  = 1'b0;
        tick();

        // Randomized traffic against the reference model.
        reset = 1'b0;
        tick();
        tick();
        reset    = 1'b1;
        m_active = 0;
        m_resp   = 0;
        m_owner  = 0;
        m_we     = 0;
        m_addr   = 0;
        m_wdata  = 0;
        e_ird    = 0;
        e_drd    = 0;
        cnt      = 0;
        ip       = 0;
        dp       = 0;
        tick();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            chk("rnd_mem_req", mem_req, m_active);
            if (m_active) begin
                chk("rnd_owner", owner, m_owner);
                chk("rnd_addr", mem_addr, m_addr);
                chk("rnd_we", mem_we, m_we);
                chk("rnd_wdata", mem_wdata, m_wdata);
            end
            chk("rnd_if_done", if_done, m_resp && !m_owner);
            chk("rnd_d_done", d_done, m_resp && m_owner);
            chk("rnd_both_done", if_done & d_done, 0);
            chk("rnd_if_rdata", if_rdata, e_ird);
            chk("rnd_d_rdata", d_rdata, e_drd);
            if (m_resp && !m_owner) ip = 0;
            if (m_resp && m_owner) dp = 0;
            if (!ip && $urandom_range(0, 2) == 0) begin
                ip      = 1;
                if_addr = {$urandom, $urandom};
            end
            if (!dp && $urandom_range(0, 2) == 0) begin
                dp      = 1;
                d_addr  = {$urandom, $urandom};
                d_wdata = {$urandom, $urandom};
                d_we    = $urandom_range(0, 1);
            end
            if_req    = ip;
            d_req     = dp;
            mem_ready = $urandom_range(0, 1);
            mem_rdata = {$urandom, $urandom};
            model_edge();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
